// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Sample-point constants below describe the default 16x oversampling.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } rx_state_t;

    localparam int DEF_OVERSAMPLE = 16;
    localparam int SAMPLE_MID     = DEF_OVERSAMPLE / 2 + 1;
    localparam int CNT_W          = $clog2(DEF_OVERSAMPLE);
    localparam int MAX_BITS       = 9;

    // Parity bit that makes the frame match the requested sense.
    function automatic logic par_calc(
        input logic [MAX_BITS-1:0] data,
        input logic                odd
    );
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/rx_sync_filter.sv
// Two-flop synchroniser for the async rx pin plus a 3-tap majority vote.
// Everything resets to the idle (high) line level.
module rx_sync_filter
    import uart_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_maj,
    output logic o_fall_edge
);

    logic [1:0] r_sync;
    logic [2:0] r_taps;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b11;
            r_taps <= 3'b111;
        end else begin
            r_sync <= {r_sync[0], i_rx};
            r_taps <= {r_taps[1:0], r_sync[1]};
        end
    end

    assign o_rx_s      = r_sync[1];
    assign o_maj       = (r_taps[0] & r_taps[1]) |
                         (r_taps[0] & r_taps[2]) |
                         (r_taps[1] & r_taps[2]);
    assign o_fall_edge = r_taps[0] & ~r_sync[1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: majority-voted sampling, runtime parity,
// false-start rejection, frame-error and break reporting.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int STOP_BITS  = 1
) (
    input  logic                 rx_clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] dataout,
    output logic                 wr_EN,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);

    localparam int L_CNT_W = $clog2(OVERSAMPLE);
    localparam int L_MID   = OVERSAMPLE / 2 + 1;

    rx_state_t r_state;
    rx_state_t w_state_next;

    logic                 w_rx_s;
    logic                 w_maj;
    logic                 w_fall;
    logic                 w_sample;
    logic                 w_last_stop;
    logic [L_CNT_W-1:0]   r_cnt;
    logic [3:0]           r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_pen;
    logic                 r_podd;
    logic                 r_pbit;
    logic                 r_ferr_acc;
    logic                 r_zero;
    logic [DATA_BITS-1:0] r_dataout;
    logic                 r_wr_en;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_brk;

    rx_sync_filter u_filt (
        .i_clk       (rx_clk),
        .i_rst_n     (rst_n),
        .i_rx        (rx),
        .o_rx_s      (w_rx_s),
        .o_maj       (w_maj),
        .o_fall_edge (w_fall)
    );

    assign w_sample = (r_cnt == L_CNT_W'(L_MID));

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_last_stop  = 1'b0;
        unique case (r_state)
            IDLE:       if (w_fall) w_state_next = START;
            START:      if (w_sample) w_state_next = w_maj ? IDLE : DATA;
            DATA: begin
                if (w_sample && r_bit_idx == 4'(DATA_BITS - 1))
                    w_state_next = r_pen ? PARITY : STOP;
            end
            PARITY:     if (w_sample) w_state_next = STOP;
            STOP: begin
                if (w_sample && (STOP_BITS == 1 || r_stop_idx)) begin
                    w_last_stop  = 1'b1;
                    w_state_next = (r_zero & ~w_maj) ? BREAK_WAIT : IDLE;
                end
            end
            BREAK_WAIT: if (w_rx_s) w_state_next = IDLE;
            default:    w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_pen      <= 1'b0;
            r_podd     <= 1'b0;
            r_pbit     <= 1'b0;
            r_ferr_acc <= 1'b0;
            r_zero     <= 1'b0;
            r_dataout  <= '0;
            r_wr_en    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_brk      <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_brk   <= 1'b0;
            if (r_state == IDLE)
                r_cnt <= '0;
            else if (r_cnt == L_CNT_W'(OVERSAMPLE - 1))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (r_state == IDLE && w_fall) begin
                r_pen      <= parity_en;
                r_podd     <= parity_odd;
                r_bit_idx  <= '0;
                r_stop_idx <= 1'b0;
                r_pbit     <= 1'b0;
                r_ferr_acc <= 1'b0;
                r_zero     <= 1'b1;
            end
            if (w_sample) begin
                case (r_state)
                    DATA: begin
                        r_shift   <= {w_maj, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 4'd1;
                        r_zero    <= r_zero & ~w_maj;
                    end
                    PARITY: begin
                        r_pbit <= w_maj;
                        r_zero <= r_zero & ~w_maj;
                    end
                    STOP: begin
                        r_stop_idx <= 1'b1;
                        r_ferr_acc <= r_ferr_acc | ~w_maj;
                        r_zero     <= r_zero & ~w_maj;
                    end
                    default: ;
                endcase
            end
            // An all-zero frame is a break, never a data word.
            if (w_last_stop) begin
                if (r_zero & ~w_maj) begin
                    r_brk <= 1'b1;
                end else begin
                    r_wr_en   <= 1'b1;
                    r_dataout <= r_shift;
                    r_perr    <= r_pen & (r_pbit !=
                                 par_calc(MAX_BITS'(r_shift), r_podd));
                    r_ferr    <= r_ferr_acc | ~w_maj;
                end
            end
        end
    end

    assign dataout    = r_dataout;
    assign wr_EN      = r_wr_en;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign break_det  = r_brk;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed and random frames against a frame-level model of the receiver.
// Observed wr_EN/break_det events are collected by a monitor and compared.
module tb_uart_rx_param;

    localparam int BIT_NS = 160;

    logic       rx_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic [7:0] dataout;
    logic       wr_EN;
    logic       parity_err;
    logic       frame_err;
    logic       break_det;
    logic       busy;

    always #5 rx_clk = ~rx_clk;

    uart_rx_param #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .STOP_BITS  (1)
    ) dut (
        .rx_clk     (rx_clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .dataout    (dataout),
        .wr_EN      (wr_EN),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .break_det  (break_det),
        .busy       (busy)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    rec_t obs_q[$];
    rec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   brk_obs = 0;
    int   brk_exp = 0;
    int   wr_extra = 0;
    int   brk_extra = 0;
    logic wr_prev = 1'b0;
    logic brk_prev = 1'b0;

    always @(negedge rx_clk) begin
        if (wr_EN) begin
            if (!wr_prev) obs_q.push_back('{d: dataout, pe: parity_err, fe: frame_err});
            else wr_extra++;
        end
        if (break_det) begin
            if (!brk_prev) brk_obs++;
            else brk_extra++;
        end
        wr_prev  = wr_EN;
        brk_prev = break_det;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Frame-level model: expected word/flags derived from the bits put on the line.
    task automatic send(input logic [7:0] d, input logic pen, input logic podd,
                        input logic pflip, input logic stop);
        int   ones;
        logic pbit;
        ones = $countones(d);
        pbit = logic'((ones % 2) == 1) ^ podd ^ pflip;
        if (d == 8'h00 && (!pen || !pbit) && !stop)
            brk_exp++;
        else
            exp_q.push_back('{d: d, pe: pen && (((ones + int'(pbit)) % 2) != int'(podd)),
                              fe: !stop});
        parity_en  = pen;
        parity_odd = podd;
        rx = 1'b0;
        #(BIT_NS);
        parity_en  = logic'($urandom_range(0, 1));
        parity_odd = logic'($urandom_range(0, 1));
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(BIT_NS);
        end
        if (pen) begin
            rx = pbit;
            #(BIT_NS);
        end
        rx = stop;
        #(BIT_NS);
    endtask

    task automatic idle(input int nbits);
        rx = 1'b1;
        #(nbits * BIT_NS);
    endtask

    task automatic verify(input string tag);
        int n;
        for (int i = 0; i < 400 && busy; i++) @(posedge rx_clk);
        #1;
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data%0d", tag, i), obs_q[i].d, exp_q[i].d);
            chk($sformatf("%s_perr%0d", tag, i), obs_q[i].pe, exp_q[i].pe);
            chk($sformatf("%s_ferr%0d", tag, i), obs_q[i].fe, exp_q[i].fe);
        end
        chk({tag, "_breaks"}, brk_obs, brk_exp);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_dataout"}, dataout, 0);
        chk({tag, "_wr"}, wr_EN, 0);
        chk({tag, "_perr"}, parity_err, 0);
        chk({tag, "_ferr"}, frame_err, 0);
        chk({tag, "_brk"}, break_det, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [7:0] d;
        logic       pen;
        logic       podd;
        logic       pflip;
        logic       stop;

        #23;
        chk_quiet("reset");
        rst_n = 1'b1;
        #100;

        send(8'hAD, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        verify("t1_8n1");

        send(8'hAD, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1);
        send(8'hAD, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(2);
        verify("t2_parity");

        rx = 1'b0;
        #40;
        rx = 1'b1;
        repeat (16) @(posedge rx_clk);
        #1;
        chk("t3_glitch_busy", busy, 0);
        send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        verify("t3_after_glitch");

        send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        send(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        verify("t4_frame");

        rx = 1'b0;
        #(12 * BIT_NS - 20);
        chk("t5_busy_low", busy, 1);
        chk("t5_break_seen", brk_obs, brk_exp + 1);
        brk_exp++;
        idle(2);
        verify("t5_break");
        send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        verify("t5_after_break");

        send(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        send(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        send(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        verify("t6_b2b");

        rx = 1'b0;
        #(BIT_NS);
        rx = 1'b1;
        #(BIT_NS);
        rx = 1'b0;
        #80;
        chk("t6_busy_mid", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_quiet("t6_midreset");
        rx = 1'b1;
        #100;
        rst_n = 1'b1;
        idle(3);
        chk("t6_no_wr", obs_q.size(), 0);
        send(8'h42, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        verify("t6_after_reset");

        for (int k = 0; k < 12; k++) begin
            d     = 8'($urandom);
            pen   = logic'($urandom_range(0, 1));
            podd  = logic'($urandom_range(0, 1));
            pflip = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 4) != 0);
            send(d, pen, podd, pflip, stop);
            if (!stop || $urandom_range(0, 1) == 1) idle(2);
        end
        idle(2);
        verify("rand");

        chk("wr_pulse_width", wr_extra, 0);
        chk("brk_pulse_width", brk_extra, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
